// File: rtl/mipi_idelay_calib_if.sv
// Calibration-side signal bundle between the MIPI RX PHY/byte_align lanes and mipi_idelay_calib.
// master = PHY/lane_align side, slave = calibration controller.
interface mipi_idelay_calib_if #(
    parameter int NUM_LANES = 2,
    parameter int TAP_W     = 5
);
    logic                       calib_start;
    logic [NUM_LANES-1:0]       sync_hit;
    logic                       invalid_start;
    logic [NUM_LANES*TAP_W-1:0] tap_value;
    logic [NUM_LANES-1:0]       tap_load;
    logic                       re_find;
    logic                       calib_busy;
    logic                       locked;
    logic [NUM_LANES-1:0]       calib_fail;

    modport master (
        output calib_start, sync_hit, invalid_start,
        input  tap_value, tap_load, re_find, calib_busy, locked, calib_fail
    );

    modport slave (
        input  calib_start, sync_hit, invalid_start,
        output tap_value, tap_load, re_find, calib_busy, locked, calib_fail
    );
endinterface

// File: rtl/mipi_idelay_calib.sv
// Per-lane IDELAY tap sweep that programs the centre of the longest good tap window.
// Optional MIPI_CALIB_AUTO_RECAL_EN: restart by itself on an invalid_start burst while locked.

module mipi_idelay_calib_lane #(
    parameter int TAP_W       = 5,
    parameter int DEFAULT_TAP = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ld,
    input  logic [TAP_W-1:0] ld_tap,
    output logic [TAP_W-1:0] tap,
    output logic             tap_load
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tap      <= TAP_W'(DEFAULT_TAP);
            tap_load <= 1'b0;
        end else begin
            tap_load <= ld;
            if (ld) tap <= ld_tap;
        end
    end
endmodule

module mipi_idelay_calib #(
    parameter int NUM_LANES   = 2,
    parameter int TAP_W       = 5,
    parameter int SETTLE_CYC  = 16,
    parameter int DWELL_CYC   = 4096,
    parameter int MIN_HITS    = 4,
    parameter int DEFAULT_TAP = 16
) (
    input  logic                clk,
    input  logic                resetn,
    mipi_idelay_calib_if.slave  cal
);
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (DWELL_CYC > SETTLE_CYC) ? DWELL_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HIT_W   = $clog2(MIN_HITS + 1);
    localparam int RUN_W   = TAP_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DWELL, SCORE, PICK, DONE, LOCKED} state_t;

    state_t                          state, state_n;
    logic [LANE_W-1:0]               lane, lane_n;
    logic [TAP_W-1:0]                tap, tap_n, ld_tap;
    logic [TAP_W-1:0]                run_start, run_start_n, best_start, best_start_n;
    logic [RUN_W-1:0]                run_len, run_len_n, best_len, best_len_n, run_inc;
    logic [CNT_W-1:0]                cnt, cnt_n;
    logic [HIT_W-1:0]                hit_cnt, hit_n;
    logic                            err, err_n;
    logic [NUM_LANES-1:0]            fail_q, fail_n, ld_req, tl_q;
    logic [NUM_LANES-1:0][TAP_W-1:0] tap_q;
    logic                            re_find_q, re_find_n, busy_q, locked_q;
    logic                            good, recal, restart;

    assign run_inc = run_len + RUN_W'(1);
    assign good    = (hit_cnt >= HIT_W'(MIN_HITS)) && !err;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mipi_idelay_calib_lane #(.TAP_W(TAP_W), .DEFAULT_TAP(DEFAULT_TAP)) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .ld       (ld_req[g]),
            .ld_tap   (ld_tap),
            .tap      (tap_q[g]),
            .tap_load (tl_q[g])
        );
    end

    assign cal.tap_value  = tap_q;
    assign cal.tap_load   = tl_q;
    assign cal.re_find    = re_find_q;
    assign cal.calib_busy = busy_q;
    assign cal.locked     = locked_q;
    assign cal.calib_fail = fail_q;

`ifdef MIPI_CALIB_AUTO_RECAL_EN
    // Free-running window from LOCKED entry; 8 bad starts inside one window force a re-sweep.
    logic [CNT_W-1:0] mon_cnt;
    logic [3:0]       inv_cnt, inv_sum;

    assign inv_sum = inv_cnt + {3'b000, cal.invalid_start};
    assign recal   = (state == LOCKED) && (inv_sum >= 4'd8);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mon_cnt <= '0;
            inv_cnt <= '0;
        end else if (state != LOCKED || mon_cnt == CNT_W'(DWELL_CYC - 1)) begin
            mon_cnt <= '0;
            inv_cnt <= '0;
        end else begin
            mon_cnt <= mon_cnt + CNT_W'(1);
            inv_cnt <= inv_sum;
        end
    end
`else
    assign recal = 1'b0;
`endif

    assign restart = cal.calib_start | recal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lane       <= '0;
            tap        <= '0;
            cnt        <= '0;
            hit_cnt    <= '0;
            err        <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            fail_q     <= '0;
            re_find_q  <= 1'b0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            tap        <= tap_n;
            cnt        <= cnt_n;
            hit_cnt    <= hit_n;
            err        <= err_n;
            run_len    <= run_len_n;
            run_start  <= run_start_n;
            best_len   <= best_len_n;
            best_start <= best_start_n;
            fail_q     <= fail_n;
            re_find_q  <= re_find_n;
            busy_q     <= state_n inside {LOAD, SETTLE, DWELL, SCORE, PICK};
            locked_q   <= (state_n == LOCKED);
        end
    end

    always_comb begin
        state_n      = state;
        lane_n       = lane;
        tap_n        = tap;
        cnt_n        = cnt;
        hit_n        = hit_cnt;
        err_n        = err;
        run_len_n    = run_len;
        run_start_n  = run_start;
        best_len_n   = best_len;
        best_start_n = best_start;
        fail_n       = fail_q;
        ld_req       = '0;
        ld_tap       = tap;
        re_find_n    = 1'b0;

        case (state)
            LOAD: begin
                ld_req[lane] = 1'b1;
                re_find_n    = 1'b1;
                cnt_n        = '0;
                state_n      = SETTLE;
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_n   = '0;
                    hit_n   = '0;
                    err_n   = 1'b0;
                    state_n = DWELL;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DWELL: begin
                if (cal.sync_hit[lane] && hit_cnt < HIT_W'(MIN_HITS)) hit_n = hit_cnt + HIT_W'(1);
                if (cal.invalid_start) err_n = 1'b1;
                if (cnt == CNT_W'(DWELL_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = SCORE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SCORE: begin
                // Strict '>' so an equal-length later window never displaces the earlier one.
                if (good) begin
                    run_len_n = run_inc;
                    if (run_len == '0) run_start_n = tap;
                    if (run_inc > best_len) begin
                        best_len_n   = run_inc;
                        best_start_n = (run_len == '0) ? tap : run_start;
                    end
                end else begin
                    run_len_n = '0;
                end
                if (tap == '1) begin
                    state_n = PICK;
                end else begin
                    tap_n   = tap + TAP_W'(1);
                    state_n = LOAD;
                end
            end
            PICK: begin
                ld_req[lane] = 1'b1;
                re_find_n    = 1'b1;
                if (best_len != '0) begin
                    ld_tap = best_start + TAP_W'((best_len - RUN_W'(1)) >> 1);
                end else begin
                    ld_tap       = TAP_W'(DEFAULT_TAP);
                    fail_n[lane] = 1'b1;
                end
                run_len_n    = '0;
                run_start_n  = '0;
                best_len_n   = '0;
                best_start_n = '0;
                if (lane == LANE_W'(NUM_LANES - 1)) begin
                    state_n = DONE;
                end else begin
                    lane_n  = lane + LANE_W'(1);
                    tap_n   = '0;
                    state_n = LOAD;
                end
            end
            DONE:    state_n = (fail_q == '0) ? LOCKED : IDLE;
            default: ;
        endcase

        // Restart wins over whatever the current state decided; picked taps stay on the lanes.
        if (restart) begin
            state_n      = LOAD;
            lane_n       = '0;
            tap_n        = '0;
            cnt_n        = '0;
            hit_n        = '0;
            err_n        = 1'b0;
            run_len_n    = '0;
            run_start_n  = '0;
            best_len_n   = '0;
            best_start_n = '0;
            fail_n       = '0;
        end
    end
endmodule
